// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU command codes, FSM states and
// flag-register bit positions.
package exe_pkg;

    localparam int CMD_W_DEF = 4;

    localparam int CMD_NOP = 0;
    localparam int CMD_ADD = 1;
    localparam int CMD_SUB = 2;
    localparam int CMD_AND = 3;
    localparam int CMD_OR  = 4;
    localparam int CMD_XOR = 5;
    localparam int CMD_NOT = 6;
    localparam int CMD_SHL = 7;
    localparam int CMD_SHR = 8;
    localparam int CMD_MUL = 9;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_CNT = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/exe_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle. done is asserted during
// the last step and product already includes that step's partial sum.
module exe_mul_iter #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = $clog2(DATA_W);

    logic                  run_q, run_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   mcand_q, mcand_d;
    logic [DATA_W-1:0]     mplier_q, mplier_d;
    logic [2*DATA_W-1:0]   acc_q, acc_d;
    logic [2*DATA_W-1:0]   acc_sum;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign done    = run_q && (cnt_q == CNT_W'(DATA_W - 1));
    assign product = acc_sum;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{DATA_W{1'b0}}, op_a};
            mplier_d = op_b;
            acc_d    = '0;
        end else if (run_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) begin
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage: ALU / input-port / immediate result selection into a registered
// EX/MEM output with valid/ready, Z/N/C flag register and an iterative multiply.
module exe_stage_pipe
    import exe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CMD_W  = CMD_W_DEF,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CMD_W-1:0]  alu_cmd,
    input  logic              is_imm,
    input  logic [DATA_W-1:0] immval,
    input  logic [DATA_W-1:0] alu_src1,
    input  logic [DATA_W-1:0] alu_src2,
    input  logic              in_port_sel,
    input  logic              out_port_sel,
    input  logic [DATA_W-1:0] in_port_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ex_out,
    output logic              zero,
    output logic              negative,
    output logic              carry,
    output logic [DATA_W-1:0] out_port_data,
    output logic              out_port_we,
    output logic              busy
);
    state_t                state_q, state_d;
    logic [DATA_W-1:0]     ex_out_q, ex_out_d;
    logic                  out_valid_q, out_valid_d;
    logic [FLAG_CNT-1:0]   flags_q, flags_d;
    logic [DATA_W-1:0]     out_port_data_q, out_port_data_d;
    logic                  out_port_we_q, out_port_we_d;

    logic                  accept, src_alu, is_mul_cmd, mul_start, mul_done;
    logic [2*DATA_W-1:0]   mul_product;
    logic [DATA_W-1:0]     alu_res, res_mux;
    logic                  alu_c;
    logic [DATA_W:0]       wide;

    assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign src_alu    = !in_port_sel && !is_imm;
    assign is_mul_cmd = (alu_cmd == CMD_W'(CMD_MUL));

    // Shifts operate on src1; unary NOT and NOP operate on src2.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        wide    = '0;
        case (alu_cmd)
            CMD_W'(CMD_ADD): begin
                wide    = {1'b0, alu_src1} + {1'b0, alu_src2};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            CMD_W'(CMD_SUB): begin
                wide    = {1'b0, alu_src1} - {1'b0, alu_src2};
                alu_res = wide[DATA_W-1:0];
                alu_c   = wide[DATA_W];
            end
            CMD_W'(CMD_AND): alu_res = alu_src1 & alu_src2;
            CMD_W'(CMD_OR):  alu_res = alu_src1 | alu_src2;
            CMD_W'(CMD_XOR): alu_res = alu_src1 ^ alu_src2;
            CMD_W'(CMD_NOT): alu_res = ~alu_src2;
            CMD_W'(CMD_SHL): begin
                alu_res = {alu_src1[DATA_W-2:0], 1'b0};
                alu_c   = alu_src1[DATA_W-1];
            end
            CMD_W'(CMD_SHR): begin
                alu_res = {1'b0, alu_src1[DATA_W-1:1]};
                alu_c   = alu_src1[0];
            end
            CMD_W'(CMD_MUL): alu_res = '0;
            default:         alu_res = alu_src2;
        endcase
    end

    assign res_mux = in_port_sel ? in_port_data : (is_imm ? immval : alu_res);

    always_comb begin
        state_d         = state_q;
        ex_out_d        = ex_out_q;
        out_valid_d     = out_valid_q && !out_ready;
        flags_d         = flags_q;
        out_port_data_d = out_port_data_q;
        out_port_we_d   = 1'b0;
        mul_start       = 1'b0;
        if (accept) begin
            if (out_port_sel) begin
                out_port_data_d = alu_src1;
                out_port_we_d   = 1'b1;
            end
            if (src_alu && is_mul_cmd && MUL_EN) begin
                state_d   = MUL;
                mul_start = 1'b1;
            end else begin
                ex_out_d    = res_mux;
                out_valid_d = 1'b1;
                // MUL without a multiplier yields 0 but must not touch flags.
                if (src_alu && !is_mul_cmd) begin
                    flags_d[FLAG_Z] = (alu_res == '0);
                    flags_d[FLAG_N] = alu_res[DATA_W-1];
                    flags_d[FLAG_C] = alu_c;
                end
            end
        end else if (state_q == MUL && mul_done) begin
            state_d         = IDLE;
            ex_out_d        = mul_product[DATA_W-1:0];
            out_valid_d     = 1'b1;
            flags_d[FLAG_Z] = (mul_product[DATA_W-1:0] == '0);
            flags_d[FLAG_N] = mul_product[DATA_W-1];
            flags_d[FLAG_C] = |mul_product[2*DATA_W-1:DATA_W];
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            exe_mul_iter #(.DATA_W(DATA_W)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start),
                .op_a    (alu_src1),
                .op_b    (alu_src2),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            ex_out_q        <= '0;
            out_valid_q     <= 1'b0;
            flags_q         <= '0;
            out_port_data_q <= '0;
            out_port_we_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            ex_out_q        <= ex_out_d;
            out_valid_q     <= out_valid_d;
            flags_q         <= flags_d;
            out_port_data_q <= out_port_data_d;
            out_port_we_q   <= out_port_we_d;
        end
    end

    assign ex_out        = ex_out_q;
    assign out_valid     = out_valid_q;
    assign zero          = flags_q[FLAG_Z];
    assign negative      = flags_q[FLAG_N];
    assign carry         = flags_q[FLAG_C];
    assign out_port_data = out_port_data_q;
    assign out_port_we   = out_port_we_q;
    assign busy          = (state_q == MUL);

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed-vector bench for exe_stage_pipe (DATA_W=8) with hand-computed results.
module tb_exe_stage_pipe;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_ready;
    logic [3:0]    alu_cmd;
    logic          is_imm;
    logic [DW-1:0] immval, alu_src1, alu_src2, in_port_data;
    logic          in_port_sel, out_port_sel;
    logic          out_valid, out_ready;
    logic [DW-1:0] ex_out, out_port_data;
    logic          zero, negative, carry, out_port_we, busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    exe_stage_pipe #(.DATA_W(DW), .CMD_W(4), .MUL_EN(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_cmd       (alu_cmd),
        .is_imm        (is_imm),
        .immval        (immval),
        .alu_src1      (alu_src1),
        .alu_src2      (alu_src2),
        .in_port_sel   (in_port_sel),
        .out_port_sel  (out_port_sel),
        .in_port_data  (in_port_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ex_out        (ex_out),
        .zero          (zero),
        .negative      (negative),
        .carry         (carry),
        .out_port_data (out_port_data),
        .out_port_we   (out_port_we),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] cmd, input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid     = 1'b1;
        alu_cmd      = cmd;
        alu_src1     = a;
        alu_src2     = b;
        is_imm       = 1'b0;
        in_port_sel  = 1'b0;
        out_port_sel = 1'b0;
    endtask

    task automatic go_idle();
        in_valid     = 1'b0;
        is_imm       = 1'b0;
        in_port_sel  = 1'b0;
        out_port_sel = 1'b0;
    endtask

    task automatic show(input string name);
        $display("txn %-8s ex_out=0x%02h valid=%0b Z=%0b N=%0b C=%0b port=0x%02h we=%0b busy=%0b",
                 name, ex_out, out_valid, zero, negative, carry, out_port_data, out_port_we, busy);
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic n, input logic c);
        check({tag, ".Z"}, {31'd0, zero}, {31'd0, z});
        check({tag, ".N"}, {31'd0, negative}, {31'd0, n});
        check({tag, ".C"}, {31'd0, carry}, {31'd0, c});
    endtask

    initial begin
        int seen_valid;
        reset = 1'b1;
        alu_cmd = '0; immval = '0; alu_src1 = '0; alu_src2 = '0; in_port_data = '0;
        out_ready = 1'b1;
        go_idle();
        step(); step();
        check("rst.ex_out", {24'd0, ex_out}, 32'h0);
        check("rst.out_valid", {31'd0, out_valid}, 32'h0);
        check("rst.busy", {31'd0, busy}, 32'h0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // ADD 0xF0 + 0x20 wraps to 0x10 with carry
        set_op(4'd1, 8'hF0, 8'h20);
        step(); show("ADD");
        go_idle();
        check("add.ex_out", {24'd0, ex_out}, 32'h10);
        check("add.out_valid", {31'd0, out_valid}, 32'h1);
        chk_flags("add", 1'b0, 1'b0, 1'b1);

        // SUB equal operands, then an immediate leaves flags alone
        set_op(4'd2, 8'h05, 8'h05);
        step(); show("SUB");
        check("sub.ex_out", {24'd0, ex_out}, 32'h00);
        chk_flags("sub", 1'b1, 1'b0, 1'b0);
        set_op(4'd1, 8'h7F, 8'h7F);
        is_imm = 1'b1; immval = 8'h80;
        step(); show("IMM");
        go_idle();
        check("imm.ex_out", {24'd0, ex_out}, 32'h80);
        check("imm.out_valid", {31'd0, out_valid}, 32'h1);
        chk_flags("imm", 1'b1, 1'b0, 1'b0);
        step();
        check("drain.out_valid", {31'd0, out_valid}, 32'h0);

        // MUL 0x13 * 0x11 = 0x143; a second op waits behind it
        set_op(4'd9, 8'h13, 8'h11);
        step();
        set_op(4'd1, 8'h03, 8'h04);
        check("mul.busy0", {31'd0, busy}, 32'h1);
        check("mul.in_ready0", {31'd0, in_ready}, 32'h0);
        for (int k = 1; k < 8; k++) begin
            step();
            check($sformatf("mul.busy%0d", k), {31'd0, busy}, 32'h1);
            check($sformatf("mul.in_ready%0d", k), {31'd0, in_ready}, 32'h0);
            check($sformatf("mul.valid%0d", k), {31'd0, out_valid}, 32'h0);
        end
        step(); show("MUL");
        check("mul.ex_out", {24'd0, ex_out}, 32'h43);
        check("mul.out_valid", {31'd0, out_valid}, 32'h1);
        check("mul.busy_end", {31'd0, busy}, 32'h0);
        chk_flags("mul", 1'b0, 1'b0, 1'b1);
        step(); show("ADD");
        go_idle();
        check("post_mul.ex_out", {24'd0, ex_out}, 32'h07);
        chk_flags("post_mul", 1'b0, 1'b0, 1'b0);
        step();

        // Backpressure: result held, then replaced back-to-back
        out_ready = 1'b0;
        set_op(4'd1, 8'h20, 8'h0A);
        step(); show("ADD");
        check("hold.ex_out", {24'd0, ex_out}, 32'h2A);
        set_op(4'd1, 8'h01, 8'h01);
        check("hold.in_ready", {31'd0, in_ready}, 32'h0);
        step();
        check("hold2.ex_out", {24'd0, ex_out}, 32'h2A);
        check("hold2.out_valid", {31'd0, out_valid}, 32'h1);
        out_ready = 1'b1;
        #1;
        check("b2b.in_ready", {31'd0, in_ready}, 32'h1);
        step(); show("ADD");
        go_idle();
        check("b2b.ex_out", {24'd0, ex_out}, 32'h02);
        check("b2b.out_valid", {31'd0, out_valid}, 32'h1);
        step();
        check("b2b.drain", {31'd0, out_valid}, 32'h0);

        // Shifts on src1
        set_op(4'd8, 8'h81, 8'h00);
        step(); show("SHR");
        check("shr.ex_out", {24'd0, ex_out}, 32'h40);
        chk_flags("shr", 1'b0, 1'b0, 1'b1);
        set_op(4'd7, 8'h80, 8'h00);
        step(); show("SHL");
        go_idle();
        check("shl.ex_out", {24'd0, ex_out}, 32'h00);
        chk_flags("shl", 1'b1, 1'b0, 1'b1);

        // Input-port result with output-port write; ALU would give 0xF3/borrow
        set_op(4'd2, 8'h33, 8'h40);
        in_port_sel = 1'b1; in_port_data = 8'h5A; out_port_sel = 1'b1;
        step(); show("INPORT");
        go_idle();
        check("port.ex_out", {24'd0, ex_out}, 32'h5A);
        chk_flags("port", 1'b1, 1'b0, 1'b1);
        check("port.data", {24'd0, out_port_data}, 32'h33);
        check("port.we", {31'd0, out_port_we}, 32'h1);
        step();
        check("port.we_off", {31'd0, out_port_we}, 32'h0);
        check("port.hold", {24'd0, out_port_data}, 32'h33);

        // Reset in the middle of a multiply abandons it
        set_op(4'd9, 8'h13, 8'h11);
        step();
        go_idle();
        step(); step(); step();
        check("rmul.busy", {31'd0, busy}, 32'h1);
        reset = 1'b1;
        step(); show("RESET");
        reset = 1'b0;
        check("rmul.ex_out", {24'd0, ex_out}, 32'h0);
        check("rmul.out_valid", {31'd0, out_valid}, 32'h0);
        check("rmul.busy0", {31'd0, busy}, 32'h0);
        check("rmul.port", {24'd0, out_port_data}, 32'h0);
        check("rmul.we", {31'd0, out_port_we}, 32'h0);
        chk_flags("rmul", 1'b0, 1'b0, 1'b0);
        seen_valid = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid) seen_valid++;
        end
        check("rmul.no_result", seen_valid, 32'd0);
        set_op(4'd1, 8'h01, 8'h02);
        step(); show("ADD");
        go_idle();
        check("after_rst.ex_out", {24'd0, ex_out}, 32'h03);
        check("after_rst.valid", {31'd0, out_valid}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
